// File: rtl/zigzag_buffer_if.sv
// Coefficient bus between the MDCT output, the zig-zag reorder stage and the quantizer.
// The master modport is the side that feeds coefficients in and drains the zig-zag stream.
interface zigzag_buffer_if;
  logic [11:0] dcti;
  logic        idv;
  logic [11:0] zzo;
  logic        zdv;
  logic        ordy;
  logic        zsob;
  logic        zeob;
  logic        ovf;

  modport master (
    output dcti, idv, ordy,
    input  zzo, zdv, zsob, zeob, ovf
  );

  modport slave (
    input  dcti, idv, ordy,
    output zzo, zdv, zsob, zeob, ovf
  );
endinterface

// File: rtl/zigzag_buffer.sv
// Double-buffered 8x8 zig-zag reorder stage: row-major coefficients in, JPEG zig-zag order out.
// One bank is filled while the other is drained through a registered valid/ready output.
module zigzag_buffer (
  input  logic           clk,
  input  logic           rst,
  zigzag_buffer_if.slave bus
);

  typedef enum logic {IDLE, RUN} rd_state_t;

  // Zig-zag index to row-major index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [11:0] mem [2][64];
  logic [1:0]  full, full_next;
  logic        wbank, rbank;
  logic [5:0]  widx, ridx;
  rd_state_t   state, state_next;

  logic wr_en, wr_drop, wr_last;
  logic out_free, issue, rd_last;

  // A sample is only refused at the start of a block; once a bank is being filled it cannot be full.
  always_comb begin
    wr_en    = bus.idv && ((widx != 6'd0) || !full[wbank]);
    wr_drop  = bus.idv && (widx == 6'd0) && full[wbank];
    wr_last  = wr_en && (widx == 6'd63);
    out_free = !bus.zdv || bus.ordy;
    issue    = full[rbank] && out_free;
    rd_last  = issue && (ridx == 6'd63);
  end

  always_comb begin
    full_next = full;
    if (wr_last) full_next[wbank] = 1'b1;
    if (rd_last) full_next[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wbank][widx] <= bus.dcti;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank   <= 1'b0;
      widx    <= 6'd0;
      full    <= 2'b00;
      bus.ovf <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_en)   widx    <= widx + 6'd1;
      if (wr_last) wbank   <= ~wbank;
      if (wr_drop) bus.ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Issue does not wait for RUN, so the first coefficient leaves the cycle after the bank fills.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (full[rbank]) state_next = RUN;
      RUN:     if (rd_last && !full_next[~rbank]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbank <= 1'b0;
      ridx  <= 6'd0;
    end else if (issue) begin
      ridx <= ridx + 6'd1;
      if (rd_last) rbank <= ~rbank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.zzo  <= 12'd0;
      bus.zdv  <= 1'b0;
      bus.zsob <= 1'b0;
      bus.zeob <= 1'b0;
    end else if (issue) begin
      bus.zzo  <= mem[rbank][ZZ[ridx]];
      bus.zdv  <= 1'b1;
      bus.zsob <= (ridx == 6'd0);
      bus.zeob <= (ridx == 6'd63);
    end else if (bus.ordy) begin
      bus.zdv  <= 1'b0;
      bus.zsob <= 1'b0;
      bus.zeob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed bench for zigzag_buffer: single block, back-to-back blocks, overflow under
// backpressure, random ready with signed extremes, and reset in the middle of a block.
module tb_zigzag_buffer;

  logic clk = 1'b0;
  logic rst;

  zigzag_buffer_if zb ();

  zigzag_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (zb)
  );

  always #5 clk = ~clk;

  int zz_ref [64] = '{
    0,  1,  8,  16, 9,  2,  3,  10,
    17, 24, 32, 25, 18, 11, 4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13, 6,  7,  14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [11:0] blk [64];
  logic [13:0] expq [$];
  logic [13:0] gotq [$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  bit rand_ordy = 1'b0;
  bit stall_prev = 1'b0;
  logic [13:0] held;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ordy) begin
      #1;
      zb.ordy = 1'($urandom_range(0, 1));
    end
  end

  // Record every transfer and confirm the output holds while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_zdv", 32'(zb.zdv), 32'd1);
        checkOutput("hold_data", 32'({zb.zsob, zb.zeob, zb.zzo}), 32'(held));
      end
      if (zb.zdv && zb.ordy) begin
        if (gotq.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        gotq.push_back({zb.zsob, zb.zeob, zb.zzo});
      end
      stall_prev = zb.zdv && !zb.ordy;
      held = {zb.zsob, zb.zeob, zb.zzo};
    end
  end

  task automatic clearQueues();
    gotq.delete();
    expq.delete();
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    zb.idv = 1'b0;
    zb.dcti = 12'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearQueues();
  endtask

  task automatic fillBlock(input int base);
    for (int i = 0; i < 64; i++) blk[i] = 12'(base + i);
  endtask

  task automatic queueBlock();
    for (int i = 0; i < 64; i++) expq.push_back({i == 0, i == 63, blk[zz_ref[i]]});
  endtask

  task automatic applyStimulus(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        zb.idv = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      zb.dcti = blk[i];
      zb.idv = 1'b1;
      @(posedge clk);
      #1;
    end
    zb.idv = 1'b0;
  endtask

  task automatic waitOutputs(input int n, input int budget);
    int k = 0;
    while (gotq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput("out_count_reached", 32'(gotq.size() >= n), 32'd1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "_count"}, 32'(gotq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < gotq.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(gotq[i]), 32'(expq[i]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    zb.ordy = 1'b1;
    zb.idv = 1'b0;
    zb.dcti = 12'd0;
    rst = 1'b1;
    doReset();
    checkOutput("rst_zzo", 32'(zb.zzo), 32'd0);
    checkOutput("rst_zdv", 32'(zb.zdv), 32'd0);
    checkOutput("rst_zsob", 32'(zb.zsob), 32'd0);
    checkOutput("rst_zeob", 32'(zb.zeob), 32'd0);
    checkOutput("rst_ovf", 32'(zb.ovf), 32'd0);

    // Single block, row-major ramp, latency to first output
    fillBlock(0);
    queueBlock();
    applyStimulus(0, 63, 1'b0);
    checkOutput("lat_k1_zdv", 32'(zb.zdv), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_k2_zdv", 32'(zb.zdv), 32'd1);
    checkOutput("lat_k2_zsob", 32'(zb.zsob), 32'd1);
    waitOutputs(64, 200);
    compareStream("single");
    checkOutput("single_ovf", 32'(zb.ovf), 32'd0);

    // Three back-to-back blocks with continuous input
    doReset();
    for (int b = 0; b < 3; b++) begin
      fillBlock(b * 64);
      queueBlock();
      applyStimulus(0, 63, 1'b0);
    end
    waitOutputs(192, 400);
    compareStream("b2b");
    checkOutput("b2b_contig", 32'(last_cyc - first_cyc), 32'd191);
    checkOutput("b2b_ovf", 32'(zb.ovf), 32'd0);

    // Ready held low: third block is dropped and ovf sets
    doReset();
    zb.ordy = 1'b0;
    fillBlock(1000);
    queueBlock();
    applyStimulus(0, 63, 1'b0);
    fillBlock(2000);
    queueBlock();
    applyStimulus(0, 63, 1'b0);
    checkOutput("bp_ovf_before", 32'(zb.ovf), 32'd0);
    fillBlock(3000);
    applyStimulus(0, 0, 1'b0);
    checkOutput("bp_ovf_set", 32'(zb.ovf), 32'd1);
    applyStimulus(1, 63, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_none_out", 32'(gotq.size()), 32'd0);
    zb.ordy = 1'b1;
    waitOutputs(128, 400);
    compareStream("bp");
    checkOutput("bp_ovf_sticky", 32'(zb.ovf), 32'd1);

    // Random ready, input gaps, signed extremes
    doReset();
    rand_ordy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 12'($urandom);
      blk[0] = 12'h800;
      blk[63] = 12'h7FF;
      blk[20 + b] = 12'hFFF;
      queueBlock();
      applyStimulus(0, 63, 1'b1);
    end
    waitOutputs(128, 2000);
    rand_ordy = 1'b0;
    @(posedge clk);
    #1;
    zb.ordy = 1'b1;
    compareStream("rand");
    checkOutput("rand_ovf", 32'(zb.ovf), 32'd0);

    // Reset after 30 samples, then a fresh block
    clearQueues();
    fillBlock(500);
    applyStimulus(0, 29, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_zzo_during", 32'(zb.zzo), 32'd0);
    checkOutput("midrst_zdv_during", 32'(zb.zdv), 32'd0);
    rst = 1'b0;
    clearQueues();
    checkOutput("midrst_zzo_after", 32'(zb.zzo), 32'd0);
    checkOutput("midrst_zdv_after", 32'(zb.zdv), 32'd0);
    fillBlock(700);
    queueBlock();
    applyStimulus(0, 63, 1'b0);
    waitOutputs(64, 200);
    compareStream("midrst");
    checkOutput("midrst_ovf", 32'(zb.ovf), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/zigzag_buffer.md
# zigzag_buffer

Double-buffered zig-zag reorder stage placed directly downstream of the MDCT 2-D DCT core. It accepts the 64 DCT coefficients of each 8x8 block, 12 bits each, in row-major order on the MDCT output strobe. It re-emits them in JPEG zig-zag order over a valid/ready interface toward the quantizer/entropy coder. Two 64-entry banks let one block be written while the previous block is read.

## Interface
- No parameters. Data width is fixed at 12 bits, block size at 64, bank count at 2.
- clk   in   1   system clock; all logic on rising edge
- rst   in   1   synchronous, active-high reset
- dcti  in   12  DCT coefficient (two's complement); connects to MDCT dcto
- idv   in   1   input valid; connects to MDCT odv; one coefficient per cycle when high
- zzo   out  12  coefficient in zig-zag order
- zdv   out  1   zzo valid
- ordy  in   1   downstream ready; a transfer occurs on a cycle with zdv && ordy
- zsob  out  1   qualifies zzo as zig-zag index 0 (DC) of a block; valid only with zdv
- zeob  out  1   qualifies zzo as zig-zag index 63; valid only with zdv
- ovf   out  1   sticky overflow flag; cleared only by rst

## Operation
- Storage: 2 banks x 64 x 12 bits, as synchronous-read RAM or registers.
- Each bank has a full flag. Write pointer wbank and read pointer rbank are 1 bit each. Write index widx and read index ridx are 6 bits each.
- Write side:
  - idv with widx = 0 and bank[wbank] not full: store dcti at bank[wbank][0] and set widx = 1.
  - idv with widx = 0 and bank[wbank] full: drop the sample, set ovf, leave widx unchanged.
  - idv with widx != 0: store at bank[wbank][widx], then increment widx. A bank being written is never full, so this always succeeds.
  - Store at widx = 63: set full[wbank], toggle wbank, wrap widx to 0.
  - dcti is ignored when idv = 0. Gaps within a block are allowed and preserve alignment.
- Read side states:
  - IDLE: full[rbank] = 0. Go to RUN when full[rbank] = 1.
  - RUN: issue read address bank[rbank][ZZ[ridx]] each time the output stage can accept. Increment ridx on each issue.
  - When the address for ridx = 63 is accepted, clear full[rbank], toggle rbank, and wrap ridx to 0. Continue in RUN if the other bank is full; otherwise go to IDLE.
- ZZ table (zig-zag index to row-major index), 64 entries: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Output stage behaviour:
  - Registered: zzo, zdv, zsob and zeob all come from flops.
  - While zdv && !ordy, zzo, zsob and zeob hold their values.
  - zsob = 1 exactly when zzo holds zig-zag index 0. zeob = 1 exactly when it holds index 63.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle both take effect: one full flag is set and the other is cleared.
  - A full flag cleared by the read side at edge t is visible to the write side at cycle t+1.
- Data is passed through bit-exact, with no arithmetic applied.

## Timing
- Reset values:
  - Outputs: zzo = 0, zdv = 0, zsob = 0, zeob = 0, ovf = 0.
  - Internal state: both full flags 0, wbank = rbank = 0, widx = ridx = 0, read FSM in IDLE.
- rst asserted mid-block discards all stored and in-flight data. On the first cycle after rst deasserts, the next idv sample is treated as row-major index 0.
- Latency: final input sample (widx = 63) in cycle k, ordy = 1, read side IDLE → first zdv with zsob in cycle k+2.
- Throughput:
  - With ordy held at 1, output is one coefficient per cycle with no gaps inside a block.
  - Continuous idv (1 sample/cycle) with ordy = 1 never sets ovf, so back-to-back blocks stream indefinitely.
- Backpressure: ordy low stalls read-address issue. No coefficient is lost or duplicated, and full flags clear only after index 63 is accepted.
- ovf sets on the cycle after the offending idv and remains 1 until rst.

## Test plan
- Single block, dcti = row-major index 0..63, ordy = 1:
  - zzo sequence equals the ZZ table (0,1,8,16,9,…,63).
  - zsob appears with the first output and zeob with the 64th.
  - First zdv arrives 2 cycles after the last idv.
  - ovf stays 0.
- Three back-to-back blocks, continuous idv, dcti = block*64 + index, ordy = 1:
  - 192 outputs with zdv continuous from first to last.
  - Each block is zig-zag ordered and offset by 64.
  - ovf stays 0.
- ordy = 0 throughout, three blocks sent:
  - First two blocks are stored.
  - The first sample of block 3 is dropped and ovf = 1 one cycle later.
  - Releasing ordy yields exactly blocks 1 and 2, in order.
- ordy toggling pseudo-randomly, signed data including -2048 and 2047:
  - Output stream equals the reference zig-zag model with no loss or duplication.
  - zzo, zsob and zeob are stable whenever zdv && !ordy.
- rst pulsed after 30 samples of a block, then one full block sent:
  - Outputs read 0 during and immediately after reset.
  - Output contains only the new block, correctly ordered.
  - ovf = 0.
